// File: rtl/i_cache_refill.sv
// Instruction-cache line refill engine: fetches BEATS words over a simple req/ack bus.
// Optional macro CRITICAL_WORD_FIRST_EN starts at the missed word and strobes it early.
module i_cache_refill #(
  parameter int unsigned BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r,
  input  logic [31:0]           mem_addr,
  output logic                  mem_ready,
  output logic [32*BEATS-1:0]   line_data,
  output logic                  bus_req,
  output logic [31:0]           bus_addr,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata,
  output logic                  busy,
  output logic                  crit_valid,
  output logic [31:0]           crit_data
);

  localparam int unsigned IDX_W = $clog2(BEATS);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam logic [31:0] BASE_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   start_idx;
  logic               beat_wr;
  logic               bus_req_d, busy_d, ready_d;
  logic [31:0]        addr_d;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_idx = mem_addr[OFF_W-1:2];
`else
  assign start_idx = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; an abort with a pending request must wait for its ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (mem_r) state_d = REQ;
      REQ: begin
        if (!mem_r)                        state_d = bus_ack ? IDLE : DRAIN;
        else if (bus_ack && cnt_q == LAST) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      DRAIN: if (bus_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; outputs are registered from these
  always_comb begin
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    beat_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_r) begin
          base_d = mem_addr & BASE_MASK;
          idx_d  = start_idx;
          cnt_d  = '0;
        end
      end
      REQ: begin
        if (mem_r && bus_ack) begin
          beat_wr = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    bus_req_d = (state_d == REQ) || (state_d == DRAIN);
    busy_d    = (state_d != IDLE);
    ready_d   = (state_d == DONE);
    addr_d    = base_d | 32'({idx_d, 2'b00});
  end

  // Registered outputs and fill bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      bus_req   <= 1'b0;
      busy      <= 1'b0;
      mem_ready <= 1'b0;
      bus_addr  <= '0;
      line_data <= '0;
    end else begin
      base_q    <= base_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bus_req   <= bus_req_d;
      busy      <= busy_d;
      mem_ready <= ready_d;
      bus_addr  <= addr_d;
      if (beat_wr) line_data[{idx_q, 5'b00000} +: 32] <= bus_rdata;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic first_wr;
  assign first_wr = beat_wr && (cnt_q == '0);

  // Early strobe of the missed word, one cycle after its beat lands
  always_ff @(posedge clk) begin
    if (!rst) begin
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= first_wr;
      if (first_wr) crit_data <= bus_rdata;
    end
  end
`else
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

endmodule
